// File: rtl/led_matrix_scanner.sv
// Column-scanned ROWS x COLS LED matrix driver with per-column blanking,
// double-buffered frame loading and configurable pin polarity.
module led_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic [ROWS*COLS-1:0]                  cells,
  input  logic                                  frame_load,
  output logic                                  load_pending,
  output logic [ROWS-1:0]                       rows,
  output logic [COLS-1:0]                       cols,
  output logic [((COLS>1)?$clog2(COLS):1)-1:0]  col_index,
  output logic                                  frame_done
);

  localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned NCELL   = ROWS * COLS;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
  localparam logic [ROWS-1:0] ROWS_OFF   = {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [COLS-1:0] COLS_OFF   = {COLS{COL_ACTIVE_LOW}};

  if (ROWS < 1 || ROWS > 32 || COLS < 1 || COLS > 32) begin : g_bad_dims
    $error("led_matrix_scanner: ROWS and COLS must be in 1..32");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("led_matrix_scanner: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 0) begin : g_bad_blank
    $error("led_matrix_scanner: BLANK_CYCLES must be >= 0");
  end

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]    col_q, col_d;
  logic [NCELL-1:0] disp_q, disp_d;
  logic [NCELL-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [ROWS-1:0]  rows_q, rows_d;
  logic [COLS-1:0]  cols_q, cols_d;
  logic             fdone_q, fdone_d;

  logic             boundary;
  logic             wrap;
  logic [ROWS-1:0]  col_bits;
  logic [COLS-1:0]  col_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      rows_q   <= ROWS_OFF;
      cols_q   <= COLS_OFF;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      fdone_q  <= fdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    disp_d     = disp_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    rows_d     = ROWS_OFF;
    cols_d     = COLS_OFF;
    fdone_d    = 1'b0;
    boundary   = 1'b0;
    wrap       = 1'b0;
    col_bits   = '0;
    col_onehot = '0;

    // Scan sequencing; the edge that starts the column-0 slot is the frame boundary
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          boundary = 1'b1;
          cnt_d    = '0;
          col_d    = '0;
          state_d  = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            if (col_q == COL_LAST) begin
              col_d    = '0;
              boundary = 1'b1;
              wrap     = 1'b1;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Display buffer only changes at a boundary, so a column never mixes two frames
    if (frame_load) begin
      shadow_d = cells;
      if (boundary) begin
        disp_d = cells;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (boundary && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end

    fdone_d = wrap;

    for (int c = 0; c < COLS; c++) begin
      col_onehot[c] = (col_d == CW'(c));
      for (int r = 0; r < ROWS; r++) begin
        if (col_d == CW'(c)) col_bits[r] = disp_d[r*COLS + c];
      end
    end

    if (state_d == DRIVE) begin
      rows_d = col_bits ^ ROWS_OFF;
      cols_d = col_onehot ^ COLS_OFF;
    end
  end

  assign load_pending = pend_q;
  assign rows         = rows_q;
  assign cols         = cols_q;
  assign col_index    = col_q;
  assign frame_done   = fdone_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: 4x3 matrix, dwell 4, blank 1,
// default polarity (rows active-low, cols active-high).
module tb_led_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        frame_load;
  logic [11:0] cells;
  logic        load_pending;
  logic [3:0]  rows;
  logic [2:0]  cols;
  logic [1:0]  col_index;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .ROWS(4), .COLS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(1),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .cells        (cells),
    .frame_load   (frame_load),
    .load_pending (load_pending),
    .rows         (rows),
    .cols         (cols),
    .col_index    (col_index),
    .frame_done   (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic blank_cyc(input int col, input logic fd);
    step();
    check($sformatf("blank%0d_cols", col), 32'(cols), 32'h0);
    check($sformatf("blank%0d_rows", col), 32'(rows), 32'hF);
    check($sformatf("blank%0d_colidx", col), 32'(col_index), 32'(col));
    check($sformatf("blank%0d_fdone", col), 32'(frame_done), 32'(fd));
  endtask

  task automatic drive(input int col, input logic [3:0] r, input int n);
    logic [2:0] oh;
    oh = 3'(1 << col);
    repeat (n) begin
      step();
      check($sformatf("drive%0d_cols", col), 32'(cols), 32'(oh));
      check($sformatf("drive%0d_rows", col), 32'(rows), 32'(r));
      check($sformatf("drive%0d_colidx", col), 32'(col_index), 32'(col));
      check($sformatf("drive%0d_fdone", col), 32'(frame_done), 32'h0);
    end
  endtask

  task automatic slot(input int col, input logic [3:0] r, input logic fd);
    blank_cyc(col, fd);
    drive(col, r, 4);
  endtask

  // Expected row pins per column (active-low), derived by hand from the cell maps
  localparam logic [3:0] A5A_C0 = 4'b0001, A5A_C1 = 4'b1100, A5A_C2 = 4'b0111;
  localparam logic [3:0] F00_C0 = 4'b1100, F00_C1 = 4'b1110, F00_C2 = 4'b1110;
  localparam logic [3:0] ALL_ON = 4'b0000, ALL_OFF = 4'b1111;

  initial begin
    int n;
    int pulses;
    rst = 1'b1; ena = 1'b1; frame_load = 1'b0; cells = 12'h000;

    // Reset held with ena high
    repeat (3) begin
      step();
      check("rst_cols", 32'(cols), 32'h0);
      check("rst_rows", 32'(rows), 32'hF);
      check("rst_colidx", 32'(col_index), 32'h0);
      check("rst_pend", 32'(load_pending), 32'h0);
      check("rst_fdone", 32'(frame_done), 32'h0);
    end

    // Checkerboard load while idle, then enable
    rst = 1'b0; ena = 1'b0; cells = 12'hA5A; frame_load = 1'b1;
    step();
    check("load_idle_pend", 32'(load_pending), 32'h1);
    check("load_idle_cols", 32'(cols), 32'h0);
    frame_load = 1'b0; ena = 1'b1;
    blank_cyc(0, 1'b0);
    check("exit_idle_pend", 32'(load_pending), 32'h0);
    drive(0, A5A_C0, 4);
    slot(1, A5A_C1, 1'b0);
    slot(2, A5A_C2, 1'b0);

    // Free run: wrap pulse, then measure the frame period between pulses
    slot(0, A5A_C0, 1'b1);
    slot(1, A5A_C1, 1'b0);
    slot(2, A5A_C2, 1'b0);
    blank_cyc(0, 1'b1);
    n = 0; pulses = 0;
    while (pulses == 0 && n < 40) begin
      step();
      n++;
      if (frame_done === 1'b1) pulses++;
    end
    check("frame_period", 32'(n), 32'd15);
    check("period_colidx", 32'(col_index), 32'h0);
    check("period_blank_cols", 32'(cols), 32'h0);
    drive(0, A5A_C0, 4);

    // Load all-on mid column 1; current frame must stay intact
    blank_cyc(1, 1'b0);
    drive(1, A5A_C1, 2);
    cells = 12'hFFF; frame_load = 1'b1;
    drive(1, A5A_C1, 1);
    frame_load = 1'b0; cells = 12'h000;
    check("mid_load_pend", 32'(load_pending), 32'h1);
    drive(1, A5A_C1, 1);
    slot(2, A5A_C2, 1'b0);
    check("pre_boundary_pend", 32'(load_pending), 32'h1);
    blank_cyc(0, 1'b1);
    check("post_boundary_pend", 32'(load_pending), 32'h0);
    drive(0, ALL_ON, 4);
    slot(1, ALL_ON, 1'b0);
    blank_cyc(2, 1'b0);
    drive(2, ALL_ON, 4);

    // Load coincident with the boundary edge takes effect immediately
    cells = 12'hA5A; frame_load = 1'b1;
    blank_cyc(0, 1'b1);
    frame_load = 1'b0;
    check("coinc_pend", 32'(load_pending), 32'h0);
    drive(0, A5A_C0, 4);

    // Two loads before a boundary: last one wins
    blank_cyc(1, 1'b0);
    drive(1, A5A_C1, 1);
    cells = 12'h0F0; frame_load = 1'b1;
    drive(1, A5A_C1, 1);
    frame_load = 1'b0;
    drive(1, A5A_C1, 2);
    blank_cyc(2, 1'b0);
    cells = 12'h00F; frame_load = 1'b1;
    drive(2, A5A_C2, 1);
    frame_load = 1'b0; cells = 12'h000;
    drive(2, A5A_C2, 3);
    blank_cyc(0, 1'b1);
    check("two_load_pend", 32'(load_pending), 32'h0);
    drive(0, F00_C0, 4);
    slot(1, F00_C1, 1'b0);

    // Drop ena mid column-2 drive with a pending frame
    blank_cyc(2, 1'b0);
    drive(2, F00_C2, 1);
    cells = 12'hFFF; frame_load = 1'b1;
    drive(2, F00_C2, 1);
    frame_load = 1'b0; cells = 12'h000;
    ena = 1'b0;
    step();
    check("ena_off_cols", 32'(cols), 32'h0);
    check("ena_off_rows", 32'(rows), 32'hF);
    check("ena_off_colidx", 32'(col_index), 32'h0);
    check("ena_off_pend", 32'(load_pending), 32'h1);
    step();
    check("idle_cols", 32'(cols), 32'h0);
    check("idle_pend", 32'(load_pending), 32'h1);
    ena = 1'b1;
    slot(0, ALL_ON, 1'b0);
    check("reenable_pend", 32'(load_pending), 32'h0);
    blank_cyc(1, 1'b0);
    drive(1, ALL_ON, 2);

    // Reset mid drive clears the display and any pending frame
    cells = 12'hA5A; frame_load = 1'b1;
    drive(1, ALL_ON, 1);
    frame_load = 1'b0;
    check("pre_rst_pend", 32'(load_pending), 32'h1);
    rst = 1'b1;
    step();
    check("mid_rst_cols", 32'(cols), 32'h0);
    check("mid_rst_rows", 32'(rows), 32'hF);
    check("mid_rst_colidx", 32'(col_index), 32'h0);
    check("mid_rst_pend", 32'(load_pending), 32'h0);
    rst = 1'b0;
    slot(0, ALL_OFF, 1'b0);
    slot(1, ALL_OFF, 1'b0);
    check("post_rst_pend", 32'(load_pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Time-multiplexed scan driver for the Conway cell-grid LED matrix. It generalises the single-column combinational driver to rectangular ROWS x COLS arrays, and adds the following:
- an internal column-scan counter with programmable dwell time;
- anti-ghosting blanking between columns;
- tear-free double-buffered frame loading;
- configurable output polarity.

It sits between the Conway state register and the board LED pins.

Parameters:
ROWS, 8, number of LED rows (1..32)
COLS, 8, number of LED columns (1..32)
DWELL_CYCLES, 1000, clocks a column is driven per scan slot (>=1)
BLANK_CYCLES, 2, clocks all outputs are off before each column is driven (>=0)
ROW_ACTIVE_LOW, 1, 1: a lit row pin is driven 0
COL_ACTIVE_LOW, 0, 1: the selected column pin is driven 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ena  input  1  scan enable; low forces the idle/off state
cells  input  ROWS*COLS  frame data; cell (r,c) = cells[r*COLS+c], 1 = lit
frame_load  input  1  capture cells into the shadow buffer at this edge
load_pending  output  1  shadow buffer holds a frame not yet displayed
rows  output  ROWS  row drive pins
cols  output  COLS  column drive pins, one-hot active when driving
col_index  output  CW  current column, where CW = (COLS>1) ? $clog2(COLS) : 1
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- All outputs are registered. "Off" is defined per pin group:
  - cols = all inactive (0s if COL_ACTIVE_LOW=0);
  - rows = all inactive (1s if ROW_ACTIVE_LOW=1).
- Reset (rst=1 at an edge) sets:
  - state=IDLE, col_index=0, slot counter=0;
  - display buffer=0, shadow=0, load_pending=0, frame_done=0;
  - rows/cols off.
  - Reset takes priority over every other input, including mid-frame.
- States:
  - IDLE: outputs off. Moves to BLANK, or to DRIVE if BLANK_CYCLES=0, at the first edge where ena=1.
  - BLANK: outputs off for BLANK_CYCLES cycles, then DRIVE.
  - DRIVE: for DWELL_CYCLES cycles:
    - cols = one-hot(col_index);
    - rows[r] = display[r*COLS+col_index], mapped through the polarity parameters.
    - At the end of DRIVE: col_index increments, wrapping COLS-1 -> 0, and the FSM enters BLANK (or DRIVE if BLANK_CYCLES=0).
- Slot length = BLANK_CYCLES + DWELL_CYCLES clocks. Frame period = COLS * slot length.
- Frame boundary is the edge that enters the column-0 slot. This includes the exit from IDLE and the wrap from COLS-1.
  - At the boundary: if load_pending=1, display <= shadow and load_pending <= 0.
  - frame_done is 1 for the single cycle following a wrap boundary. It is not asserted on the exit from IDLE.
- frame_load=1 at an edge:
  - shadow <= cells, load_pending <= 1.
  - If the same edge is a frame boundary, display <= cells directly and load_pending stays 0.
  - A second load before the boundary overwrites the shadow (last wins).
- The display buffer never changes except at a boundary. This makes tearing impossible.
- ena falls at an edge (any state):
  - next state IDLE, outputs off, col_index=0, counter=0;
  - shadow and load_pending are preserved.
  - A re-enable restarts at column 0 with a boundary swap.
- Elaboration $error if:
  - ROWS or COLS is outside 1..32, or
  - DWELL_CYCLES < 1, or
  - BLANK_CYCLES < 0.

Test Plan:
Bench parameters for all scenarios: ROWS=4, COLS=3, DWELL_CYCLES=4, BLANK_CYCLES=1, default polarity.
1. Reset held 3 cycles with ena=1 -> cols=3'b000, rows=4'b1111, col_index=0, load_pending=0, frame_done=0 throughout.
2. Load checkerboard cells=12'hA5A with frame_load at edge 0, then ena=1 from edge 1 ->
   - 1 blank cycle, then cols=3'b001 for 4 cycles with rows = ~{cell(3,0),cell(2,0),cell(1,0),cell(0,0)};
   - then 1 blank cycle, then cols=3'b010;
   - frame period measures 15 clocks.
3. Free-run 3 frames -> col_index sequence 0,1,2,0, and frame_done is a one-cycle pulse every 15 clocks, aligned with the column-0 blank.
4. Assert frame_load with cells=12'hFFF mid-column-1 ->
   - load_pending=1;
   - rows unchanged for columns 1 and 2;
   - all rows lit from the next column-0 slot;
   - load_pending=0 after the boundary.
5. frame_load coincident with the boundary edge -> the new frame is shown in column 0 immediately and load_pending stays 0. Two loads before a boundary -> only the second frame is displayed.
6. Drop ena during column 2 DRIVE ->
   - outputs off on the next cycle, col_index=0;
   - re-enable resumes at column 0 after 1 blank cycle.
   - Separately, asserting rst mid-DRIVE clears load_pending and the display buffer (rows all 1s after restart).
